shifter_right_iter: RTL
=======================

# shifter_right_iter

Iterative 16-bit right-direction shifter for the execute stage. It is the sequential counterpart to the combinational left-rotate barrel stages. It accepts an operand, a 4-bit count and an opcode on a start pulse, then applies the 8/4/2/1 shift stages on successive cycles. It returns the result with a one-cycle done pulse, which lets the ALU issue multi-cycle shifts without a full combinational barrel in the critical path.

## Interface
- WIDTH, 16: operand width; stage sequence 8/4/2/1 is fixed for 16.
- CNT_W, 4: count width, log2(WIDTH).
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- In  input  16  operand.
- Cnt  input  4  shift/rotate amount, 0..15.
- Op  input  2  00 ROR, 01 SRL, 10 SRA, 11 ROL.
- Out  output  16  result register; holds until next completion.
- busy  output  1  high while in S8, S4, S2 or S1.
- done  output  1  one-cycle pulse, Out valid in same cycle.

## Operation
- States:
  - IDLE -> S8 on start.
  - S8 -> S4 -> S2 -> S1 unconditionally.
  - S1 -> IDLE.
- Accept, on the edge where state is IDLE and start is 1:
  - Latch data <= In and op <= Op.
  - amt <= Cnt for ROR/SRL/SRA.
  - amt <= (16 - Cnt) mod 16 for ROL; the ROL is executed as a ROR.
  - sign <= In[15].
- Stage k (k = 8,4,2,1), in state Sk:
  - If amt bit log2(k) is 1, data <= data shifted right by k; otherwise data is unchanged.
  - ROR/ROL: vacated upper k bits take data[k-1:0].
  - SRL: vacated bits take 0.
  - SRA: vacated bits take the latched sign.
- Completion, on the S1 edge: Out <= stage-1 result, done <= 1, state <= IDLE.
- done deasserts on the next edge unless a new op completes then.
- Out is unchanged outside the completion edge.
- Cnt = 0: Out = In after full 4-cycle latency. There is no early exit.
- start while busy: ignored and not queued. Latched operands are unaffected by changes on In, Cnt or Op during busy.
- start in the done cycle: state is IDLE, so it is accepted. Back-to-back throughput is one op per 5 cycles.

## Timing
- Reset (rst = 1 at edge):
  - state <= IDLE, Out <= 16'h0000, busy <= 0, done <= 0.
  - Internal data, amt and op cleared.
  - Overrides start in the same cycle.
- Reset mid-operation: the op is aborted, done never pulses for it, and Out is 0 after reset.
- Latency: start sampled at edge E. busy is 1 in cycles E..E+3. done and Out are valid in the cycle after edge E+4, which is 4 cycles after start.
- busy is a decode of the registered state, so there are no combinational paths from inputs to outputs.
- No backpressure: the consumer must capture Out on done or before the next completion.

## Test plan
- Reset then ROR: rst then idle; start, In=16'h1234, Cnt=4, Op=00. Required: Out=16'h4123, done high exactly 4 cycles after start, busy high for 4 cycles, Out=16'h0000 before completion.
- SRA/SRL contrast: In=16'h8000, Cnt=15. Op=10 gives Out=16'hFFFF; Op=01 gives Out=16'h0001. Also In=16'h7FF0, Cnt=4, Op=10 gives 16'h07FF.
- ROL mapping: In=16'h00FF, Cnt=8, Op=11 gives 16'hFF00. In=16'h8001, Cnt=1, Op=11 gives 16'h0003. Cnt=0, Op=11 gives In unchanged after 4 cycles.
- Ignored start: start the op 16'hABCD, Cnt=1, Op=00. Pulse start with different In/Cnt while busy. Required: single done, Out=16'hD5E6, no second done.
- Back-to-back: assert start in the done cycle with In=16'h0F00, Cnt=8, Op=01. Required: accepted; next done 4 cycles later with Out=16'h000F; first Out held until then.
- Reset mid-op: assert rst in state S2. Required: busy=0, done never pulses for that op, Out=16'h0000. A following start completes normally.

Source files
------------

// File: rtl/shifter_right_iter.sv
// shifter_right_iter
// Iterative right shifter / rotator for the execute stage. An operand is
// accepted on a start pulse and then passes through the 8, 4, 2 and 1 bit
// stages on four successive cycles. The result is registered on the last
// stage, and done pulses for one cycle at the same time.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only while idle
//   In     in   WIDTH  operand
//   Cnt    in   CNT_W  amount, 0..WIDTH-1
//   Op     in   2      00 ROR, 01 SRL, 10 SRA, 11 ROL
//   Out    out  WIDTH  result register, held until the next completion
//   busy   out  1      high while a stage is in progress
//   done   out  1      one-cycle completion pulse, Out valid with it
module shifter_right_iter #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] In,
   input  logic [CNT_W-1:0] Cnt,
   input  logic [1:0]       Op,
   output logic [WIDTH-1:0] Out,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S8   = 3'd1,
      ST_S4   = 3'd2,
      ST_S2   = 3'd3,
      ST_S1   = 3'd4
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] data_r;
   logic [CNT_W-1:0] amt_r;
   logic [1:0]       op_r;
   logic             sign_r;
   logic [WIDTH-1:0] out_r;
   logic             busy_r;
   logic             done_r;

   logic [4:0]       k_s;
   logic             amt_bit_s;
   logic [WIDTH-1:0] stage_res_s;

   // One shift stage of k bits. The operand is placed under an upper half
   // holding the fill pattern, so a plain right shift brings the correct
   // bits into the vacated positions. ROL reaches here as a ROR.
   function automatic logic [WIDTH-1:0] shift_stage(
      input logic [WIDTH-1:0] d,
      input logic [4:0]       k,
      input logic [1:0]       op,
      input logic             sign
   );
      logic [2*WIDTH-1:0] ext;
      logic [2*WIDTH-1:0] shifted;
      case (op)
         OP_ROR:  ext = {d, d};
         OP_ROL:  ext = {d, d};
         OP_SRL:  ext = {{WIDTH{1'b0}}, d};
         OP_SRA:  ext = {{WIDTH{sign}}, d};
         default: ext = {{WIDTH{1'b0}}, d};
      endcase
      shifted = ext >> k;
      return shifted[WIDTH-1:0];
   endfunction

   // Pick this cycle's stage width and its controlling amount bit, then form the stage result.
   always_comb begin
      k_s       = 5'd0;
      amt_bit_s = 1'b0;
      case (state_r)
         ST_S8: begin
            k_s       = 5'd8;
            amt_bit_s = amt_r[3];
         end
         ST_S4: begin
            k_s       = 5'd4;
            amt_bit_s = amt_r[2];
         end
         ST_S2: begin
            k_s       = 5'd2;
            amt_bit_s = amt_r[1];
         end
         ST_S1: begin
            k_s       = 5'd1;
            amt_bit_s = amt_r[0];
         end
         default: begin
            k_s       = 5'd0;
            amt_bit_s = 1'b0;
         end
      endcase
      if (amt_bit_s) begin
         stage_res_s = shift_stage(data_r, k_s, op_r, sign_r);
      end else begin
         stage_res_s = data_r;
      end
   end

   // Sequencer: accept, step through the four stages, register the result and pulse done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         data_r  <= {WIDTH{1'b0}};
         amt_r   <= {CNT_W{1'b0}};
         op_r    <= 2'b00;
         sign_r  <= 1'b0;
         out_r   <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  data_r <= In;
                  op_r   <= Op;
                  sign_r <= In[WIDTH-1];
                  // A left rotate by n equals a right rotate by (WIDTH - n) mod WIDTH.
                  if (Op == OP_ROL) begin
                     amt_r <= {CNT_W{1'b0}} - Cnt;
                  end else begin
                     amt_r <= Cnt;
                  end
                  busy_r  <= 1'b1;
                  state_r <= ST_S8;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_S8: begin
               data_r  <= stage_res_s;
               state_r <= ST_S4;
            end
            ST_S4: begin
               data_r  <= stage_res_s;
               state_r <= ST_S2;
            end
            ST_S2: begin
               data_r  <= stage_res_s;
               state_r <= ST_S1;
            end
            ST_S1: begin
               data_r  <= stage_res_s;
               out_r   <= stage_res_s;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign Out  = out_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule
